// File: rtl/alu_ctrl.sv
// Command sequencer around a combinational ALU: 8-entry register file, valid/ready command
// and response channels. Define ALU_CTRL_B2B_EN to accept a new command during the response handshake.
module alu_ctrl #(
    parameter int DWIDTH = 32,
    parameter int NREG   = 8,
    parameter int AWIDTH = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_ld,
    input  logic [2:0]        i_cmd_f,
    input  logic [AWIDTH-1:0] i_cmd_ra,
    input  logic [AWIDTH-1:0] i_cmd_rb,
    input  logic [AWIDTH-1:0] i_cmd_rd,
    input  logic [DWIDTH-1:0] i_cmd_imm,
    output logic [DWIDTH-1:0] o_alu_a,
    output logic [DWIDTH-1:0] o_alu_b,
    output logic [2:0]        o_alu_f,
    input  logic [DWIDTH-1:0] i_alu_y,
    input  logic              i_alu_c,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DWIDTH-1:0] o_rsp_y,
    output logic              o_rsp_c,
    output logic [AWIDTH-1:0] o_rsp_rd,
    output logic              o_rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [2:0]        F_ILLEGAL = 3'b011;
    localparam logic [AWIDTH-1:0] REG_ZERO  = {AWIDTH{1'b0}};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DWIDTH-1:0]   regs_r [NREG];
    logic [DWIDTH-1:0]   alu_a_r;
    logic [DWIDTH-1:0]   alu_b_r;
    logic [2:0]          alu_f_r;
    logic [DWIDTH-1:0]   rsp_y_r;
    logic                rsp_c_r;
    logic [AWIDTH-1:0]   rsp_rd_r;
    logic                rsp_err_r;
    logic                cmd_ready_s;
    logic                accept_s;
    logic [DWIDTH-1:0]   rdata_a_s;
    logic [DWIDTH-1:0]   rdata_b_s;
    logic                wr_en_s;
    logic [AWIDTH-1:0]   wr_addr_s;
    logic [DWIDTH-1:0]   wr_data_s;

    // Command-ready decode; held low throughout reset.
    always_comb begin
        cmd_ready_s = 1'b0;
        if (i_rst) begin
            cmd_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: cmd_ready_s = 1'b1;
`ifdef ALU_CTRL_B2B_EN
                ST_RESP: cmd_ready_s = i_rsp_ready;
`else
                ST_RESP: cmd_ready_s = 1'b0;
`endif
                default: cmd_ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s = i_cmd_valid & cmd_ready_s;

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = i_cmd_ld ? ST_RESP : ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (i_rsp_ready && accept_s) begin
                    state_nxt_s = i_cmd_ld ? ST_RESP : ST_EXEC;
                end else if (i_rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Source reads; R0 is hard-wired to zero.
    always_comb begin
        rdata_a_s = {DWIDTH{1'b0}};
        rdata_b_s = {DWIDTH{1'b0}};
        if (i_cmd_ra != REG_ZERO) begin
            rdata_a_s = regs_r[i_cmd_ra];
        end else begin
            rdata_a_s = {DWIDTH{1'b0}};
        end
        if (i_cmd_rb != REG_ZERO) begin
            rdata_b_s = regs_r[i_cmd_rb];
        end else begin
            rdata_b_s = {DWIDTH{1'b0}};
        end
    end

    // Single write port: ALU write-back in EXEC, immediate load on accept (never both).
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = REG_ZERO;
        wr_data_s = {DWIDTH{1'b0}};
        if ((state_r == ST_EXEC) && (alu_f_r != F_ILLEGAL)) begin
            wr_en_s   = 1'b1;
            wr_addr_s = rsp_rd_r;
            wr_data_s = i_alu_y;
        end else if (accept_s && i_cmd_ld) begin
            wr_en_s   = 1'b1;
            wr_addr_s = i_cmd_rd;
            wr_data_s = i_cmd_imm;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Register file storage; writes to R0 are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DWIDTH{1'b0}};
            end
        end else if (wr_en_s && (wr_addr_s != REG_ZERO)) begin
            regs_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Operand and function-code registers feeding the ALU.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            alu_a_r <= {DWIDTH{1'b0}};
            alu_b_r <= {DWIDTH{1'b0}};
            alu_f_r <= 3'b000;
        end else if (accept_s && !i_cmd_ld) begin
            alu_a_r <= rdata_a_s;
            alu_b_r <= rdata_b_s;
            alu_f_r <= i_cmd_f;
        end
    end

    // Response fields: destination on accept, data on load accept or ALU capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_y_r   <= {DWIDTH{1'b0}};
            rsp_c_r   <= 1'b0;
            rsp_rd_r  <= REG_ZERO;
            rsp_err_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            if (alu_f_r == F_ILLEGAL) begin
                rsp_y_r   <= {DWIDTH{1'b0}};
                rsp_c_r   <= 1'b0;
                rsp_err_r <= 1'b1;
            end else begin
                rsp_y_r   <= i_alu_y;
                rsp_c_r   <= i_alu_c;
                rsp_err_r <= 1'b0;
            end
        end else if (accept_s) begin
            rsp_rd_r <= i_cmd_rd;
            if (i_cmd_ld) begin
                rsp_y_r   <= i_cmd_imm;
                rsp_c_r   <= 1'b0;
                rsp_err_r <= 1'b0;
            end
        end
    end

    assign o_cmd_ready = cmd_ready_s;
    assign o_alu_a     = alu_a_r;
    assign o_alu_b     = alu_b_r;
    assign o_alu_f     = alu_f_r;
    assign o_rsp_valid = (state_r == ST_RESP);
    assign o_rsp_y     = rsp_y_r;
    assign o_rsp_c     = rsp_c_r;
    assign o_rsp_rd    = rsp_rd_r;
    assign o_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl (default build) with a small behavioural ALU attached.
module tb_alu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_ld = 1'b0;
    logic [2:0]  i_cmd_f = 3'b000;
    logic [2:0]  i_cmd_ra = 3'd0;
    logic [2:0]  i_cmd_rb = 3'd0;
    logic [2:0]  i_cmd_rd = 3'd0;
    logic [31:0] i_cmd_imm = 32'd0;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic [2:0]  o_alu_f;
    logic [31:0] i_alu_y;
    logic        i_alu_c;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_y;
    logic        o_rsp_c;
    logic [2:0]  o_rsp_rd;
    logic        o_rsp_err;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    alu_ctrl #(.DWIDTH(32), .NREG(8), .AWIDTH(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_ld(i_cmd_ld), .i_cmd_f(i_cmd_f),
        .i_cmd_ra(i_cmd_ra), .i_cmd_rb(i_cmd_rb), .i_cmd_rd(i_cmd_rd),
        .i_cmd_imm(i_cmd_imm),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_f(o_alu_f),
        .i_alu_y(i_alu_y), .i_alu_c(i_alu_c),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_y(o_rsp_y), .o_rsp_c(o_rsp_c), .o_rsp_rd(o_rsp_rd), .o_rsp_err(o_rsp_err)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural ALU; code 011 deliberately produces garbage the controller must discard.
    always_comb begin
        i_alu_y = 32'd0;
        i_alu_c = 1'b0;
        case (o_alu_f)
            3'b000: i_alu_y = o_alu_a & o_alu_b;
            3'b001: i_alu_y = o_alu_a | o_alu_b;
            3'b010: {i_alu_c, i_alu_y} = {1'b0, o_alu_a} + {1'b0, o_alu_b};
            3'b011: begin i_alu_y = 32'hBAD0_BAD0; i_alu_c = 1'b1; end
            3'b100: i_alu_y = o_alu_a ^ o_alu_b;
            3'b110: {i_alu_c, i_alu_y} = {1'b0, o_alu_a} - {1'b0, o_alu_b};
            default: i_alu_y = ~(o_alu_a | o_alu_b);
        endcase
    end

    task automatic send_cmd(input logic ld, input logic [2:0] f, input logic [2:0] ra,
                            input logic [2:0] rb, input logic [2:0] rd, input logic [31:0] imm);
        bit ok = 1'b0;
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_ld = ld; i_cmd_f = f;
        i_cmd_ra = ra; i_cmd_rb = rb; i_cmd_rd = rd; i_cmd_imm = imm;
        for (int i = 0; i < 20; i++) begin
            if (o_cmd_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge i_clk);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL cmd_accept_timeout: o_cmd_ready=%b, required 1 within 20 cycles", o_cmd_ready);
        end
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int l);
        l = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_clk);
            if (o_rsp_valid === 1'b1) begin l = i; break; end
        end
        if (l == 0) begin
            n_checks++;
            $display("FAIL rsp_timeout: o_rsp_valid=%b, required 1 within 20 cycles", o_rsp_valid);
        end
    endtask

    task automatic ack_rsp();
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1 i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        n_checks++;
        if (o_cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", o_cmd_ready); else n_pass++;
        n_checks++;
        if (o_rsp_valid !== 1'b0 || o_rsp_err !== 1'b0) $display("FAIL reset_rsp: valid=%b err=%b want 0 0", o_rsp_valid, o_rsp_err); else n_pass++;
        n_checks++;
        if (o_alu_a !== 32'd0 || o_alu_b !== 32'd0 || o_alu_f !== 3'd0)
            $display("FAIL reset_alu: a=%h b=%h f=%b want all zero", o_alu_a, o_alu_b, o_alu_f);
        else n_pass++;
        n_checks++;
        if (o_rsp_y !== 32'd0 || o_rsp_rd !== 3'd0) $display("FAIL reset_rsp_fields: y=%h rd=%0d want 0 0", o_rsp_y, o_rsp_rd); else n_pass++;
        i_rst = 1'b0;
        #1;
        n_checks++;
        if (o_cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready: got %b want 1", o_cmd_ready); else n_pass++;
    endtask

    task automatic test_load_add();
        send_cmd(1'b1, 3'b000, 3'd0, 3'd0, 3'd1, 32'hFFFF_FFFF);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 1 || o_rsp_y !== 32'hFFFF_FFFF || o_rsp_c !== 1'b0 || o_rsp_rd !== 3'd1 || o_rsp_err !== 1'b0)
            $display("FAIL load_r1: lat=%0d y=%h c=%b rd=%0d err=%b want 1 ffffffff 0 1 0", lat, o_rsp_y, o_rsp_c, o_rsp_rd, o_rsp_err);
        else n_pass++;
        ack_rsp();
        send_cmd(1'b1, 3'b000, 3'd0, 3'd0, 3'd2, 32'h0000_0001);
        wait_rsp(lat);
        n_checks++;
        if (o_rsp_y !== 32'h1 || o_rsp_rd !== 3'd2) $display("FAIL load_r2: y=%h rd=%0d want 1 2", o_rsp_y, o_rsp_rd); else n_pass++;
        ack_rsp();
        send_cmd(1'b0, 3'b010, 3'd1, 3'd2, 3'd3, 32'd0);
        @(negedge i_clk);
        n_checks++;
        if (o_alu_a !== 32'hFFFF_FFFF || o_alu_b !== 32'h1 || o_alu_f !== 3'b010 || o_rsp_valid !== 1'b0)
            $display("FAIL exec_operands: a=%h b=%h f=%b valid=%b want ffffffff 1 010 0", o_alu_a, o_alu_b, o_alu_f, o_rsp_valid);
        else n_pass++;
        wait_rsp(lat);
        n_checks++;
        if (lat !== 1 || o_rsp_y !== 32'd0 || o_rsp_c !== 1'b1 || o_rsp_rd !== 3'd3 || o_rsp_err !== 1'b0)
            $display("FAIL add_carry: extra_lat=%0d y=%h c=%b rd=%0d err=%b want 1 0 1 3 0", lat, o_rsp_y, o_rsp_c, o_rsp_rd, o_rsp_err);
        else n_pass++;
        ack_rsp();
        send_cmd(1'b0, 3'b001, 3'd3, 3'd3, 3'd4, 32'd0);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 2 || o_rsp_y !== 32'd0 || o_rsp_rd !== 3'd4)
            $display("FAIL or_r3: lat=%0d y=%h rd=%0d want 2 0 4", lat, o_rsp_y, o_rsp_rd);
        else n_pass++;
        ack_rsp();
        send_cmd(1'b0, 3'b100, 3'd1, 3'd2, 3'd4, 32'd0);
        wait_rsp(lat);
        n_checks++;
        if (o_rsp_y !== 32'hFFFF_FFFE) $display("FAIL xor_r1_r2: y=%h want fffffffe", o_rsp_y); else n_pass++;
        ack_rsp();
    endtask

    task automatic test_r0();
        send_cmd(1'b1, 3'b000, 3'd0, 3'd0, 3'd1, 32'd5);
        wait_rsp(lat); ack_rsp();
        send_cmd(1'b1, 3'b000, 3'd0, 3'd0, 3'd2, 32'd3);
        wait_rsp(lat); ack_rsp();
        send_cmd(1'b0, 3'b110, 3'd1, 3'd2, 3'd0, 32'd0);
        wait_rsp(lat);
        n_checks++;
        if (o_rsp_y !== 32'd2 || o_rsp_rd !== 3'd0) $display("FAIL sub_to_r0: y=%h rd=%0d want 2 0", o_rsp_y, o_rsp_rd); else n_pass++;
        ack_rsp();
        send_cmd(1'b0, 3'b001, 3'd0, 3'd0, 3'd4, 32'd0);
        wait_rsp(lat);
        n_checks++;
        if (o_rsp_y !== 32'd0) $display("FAIL r0_after_alu_write: y=%h want 0", o_rsp_y); else n_pass++;
        ack_rsp();
        send_cmd(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 32'hDEAD_BEEF);
        wait_rsp(lat);
        n_checks++;
        if (o_rsp_y !== 32'hDEAD_BEEF) $display("FAIL load_r0_rsp: y=%h want deadbeef", o_rsp_y); else n_pass++;
        ack_rsp();
        send_cmd(1'b0, 3'b010, 3'd0, 3'd1, 3'd4, 32'd0);
        wait_rsp(lat);
        n_checks++;
        if (o_rsp_y !== 32'd5) $display("FAIL r0_after_load: y=%h want 5", o_rsp_y); else n_pass++;
        ack_rsp();
    endtask

    task automatic test_illegal();
        send_cmd(1'b1, 3'b000, 3'd0, 3'd0, 3'd5, 32'h1234_5678);
        wait_rsp(lat); ack_rsp();
        send_cmd(1'b0, 3'b011, 3'd1, 3'd2, 3'd5, 32'd0);
        wait_rsp(lat);
        n_checks++;
        if (o_rsp_err !== 1'b1 || o_rsp_y !== 32'd0 || o_rsp_c !== 1'b0 || o_rsp_rd !== 3'd5)
            $display("FAIL illegal_f: err=%b y=%h c=%b rd=%0d want 1 0 0 5", o_rsp_err, o_rsp_y, o_rsp_c, o_rsp_rd);
        else n_pass++;
        ack_rsp();
        send_cmd(1'b0, 3'b001, 3'd5, 3'd5, 3'd4, 32'd0);
        wait_rsp(lat);
        n_checks++;
        if (o_rsp_y !== 32'h1234_5678 || o_rsp_err !== 1'b0)
            $display("FAIL r5_unchanged: y=%h err=%b want 12345678 0", o_rsp_y, o_rsp_err);
        else n_pass++;
        ack_rsp();
    endtask

    task automatic test_back_to_back();
        send_cmd(1'b0, 3'b010, 3'd1, 3'd2, 3'd4, 32'd0);
        wait_rsp(lat);
        i_cmd_valid = 1'b1; i_cmd_ld = 1'b1; i_cmd_rd = 3'd7; i_cmd_imm = 32'h55;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_y !== 32'd8 || o_rsp_rd !== 3'd4 || o_cmd_ready !== 1'b0)
                $display("FAIL hold_cycle%0d: valid=%b y=%h rd=%0d ready=%b want 1 8 4 0", i, o_rsp_valid, o_rsp_y, o_rsp_rd, o_cmd_ready);
            else n_pass++;
            @(negedge i_clk);
        end
        ack_rsp();
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
        wait_rsp(lat);
        n_checks++;
        if (lat !== 1 || o_rsp_y !== 32'h55 || o_rsp_rd !== 3'd7)
            $display("FAIL queued_load: lat=%0d y=%h rd=%0d want 1 55 7", lat, o_rsp_y, o_rsp_rd);
        else n_pass++;
        ack_rsp();
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_rsp_valid !== 1'b0) $display("FAIL extra_accept%0d: valid=%b want 0", i, o_rsp_valid); else n_pass++;
        end
    endtask

    task automatic test_reset_exec();
        send_cmd(1'b1, 3'b000, 3'd0, 3'd0, 3'd1, 32'd7);
        wait_rsp(lat); ack_rsp();
        send_cmd(1'b1, 3'b000, 3'd0, 3'd0, 3'd2, 32'd9);
        wait_rsp(lat); ack_rsp();
        send_cmd(1'b0, 3'b010, 3'd1, 3'd2, 3'd6, 32'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b0)
            $display("FAIL rst_exec_a: valid=%b ready=%b want 0 0", o_rsp_valid, o_cmd_ready);
        else n_pass++;
        @(negedge i_clk);
        n_checks++;
        if (o_rsp_valid !== 1'b0 || o_alu_a !== 32'd0 || o_rsp_y !== 32'd0)
            $display("FAIL rst_exec_b: valid=%b alu_a=%h y=%h want 0 0 0", o_rsp_valid, o_alu_a, o_rsp_y);
        else n_pass++;
        i_rst = 1'b0;
        #1;
        n_checks++;
        if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0)
            $display("FAIL rst_exec_release: ready=%b valid=%b want 1 0", o_cmd_ready, o_rsp_valid);
        else n_pass++;
        send_cmd(1'b0, 3'b001, 3'd6, 3'd6, 3'd4, 32'd0);
        wait_rsp(lat);
        n_checks++;
        if (o_rsp_y !== 32'd0) $display("FAIL r6_after_reset: y=%h want 0", o_rsp_y); else n_pass++;
        ack_rsp();
        send_cmd(1'b0, 3'b001, 3'd1, 3'd1, 3'd4, 32'd0);
        wait_rsp(lat);
        n_checks++;
        if (o_rsp_y !== 32'd0) $display("FAIL r1_after_reset: y=%h want 0", o_rsp_y); else n_pass++;
        ack_rsp();
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_r0();
        test_illegal();
        test_back_to_back();
        test_reset_exec();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
